rbus_eve_cfg_bank: RTL and testbench
====================================

Name: rbus_eve_cfg_bank

Overview:
Generic ring-bus event-driven configuration bank: the next generation of the per-device config-register front end used by ring-bus peripherals such as the VGA box.
- Decodes r2d event commands into NUM_REGS parametrised 40-bit registers.
- Buffers a byte stream (e.g. text characters) in a FIFO of FIFO_DEPTH entries, replacing the old single-slot strobe.
- Adds register readback through d2r response events.
- Sits between the ring-bus device port and the device core.

Parameters:
- NUM_REGS, 8: number of config registers; legal range 1..16.
- CMD_BASE, 8'h20: command code of register 0. Register i is CMD_BASE+i. PUSH = CMD_BASE+NUM_REGS. READ = CMD_BASE+NUM_REGS+1. RSP = CMD_BASE+NUM_REGS+2.
- INI_VALS, 0: flattened NUM_REGS*40-bit reset values; register i occupies [40*i+39:40*i].
- FIFO_DEPTH, 4: stream FIFO depth; power of 2, at least 2.
- FIFO_W, 8: stream data width, taken from ptr[FIFO_W-1:0].
- DEV_ID, 8'h00: value driven on d2r_eve_dev in responses.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- soft_rst  in  1  synchronous soft reset; same effect as rst
- r2d_eve_stb  in  1  incoming event valid; held by the ring until acked
- r2d_eve_cmd  in  8  event command
- r2d_eve_ptr  in  40  event payload
- r2d_eve_ack  out  1  event consumed this cycle (combinational)
- d2r_eve_stb  out  1  response event valid
- d2r_eve_cmd  out  8  response command (RSP)
- d2r_eve_dev  out  8  DEV_ID
- d2r_eve_ptr  out  40  response payload
- d2r_eve_ack  in  1  response taken by the ring
- cfg_regs  out  NUM_REGS*40  register contents, flattened
- cfg_upd  out  NUM_REGS  one-cycle pulse per register on write
- str_stb  out  1  stream head valid (FIFO not empty)
- str_data  out  FIFO_W  stream head data
- str_ack  in  1  consumer pops the head
- str_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Effective reset = rst | soft_rst, sampled on the rising edge of clk.
- Reset values: cfg_regs = INI_VALS; cfg_upd = 0; d2r_eve_stb = 0; d2r_eve_cmd/dev/ptr = 0; FIFO empty; str_stb = 0; str_level = 0.
- At most one event is handled per cycle. r2d_eve_ack is high only when r2d_eve_stb is high and the event is accepted; otherwise the event stalls.
- Register write (cmd = CMD_BASE+i, i < NUM_REGS):
  - Always accepted.
  - Register i <= ptr on the next edge.
  - cfg_upd[i] pulses high for exactly 1 cycle, aligned with the new value.
- PUSH:
  - Accepted iff str_level < FIFO_DEPTH, judged on the registered count. A push into a full FIFO is not accepted even if a pop occurs in the same cycle, so there is no ack path from str_ack.
  - Data is visible on str_stb/str_data 1 cycle after ack.
- FIFO:
  - Show-ahead: str_data = head whenever str_stb = 1.
  - Pop on str_stb && str_ack.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Empty when level = 0.
  - str_ack while empty is ignored.
- READ:
  - Accepted iff d2r_eve_stb = 0.
  - Next cycle: d2r_eve_stb = 1, d2r_eve_cmd = RSP, d2r_eve_dev = DEV_ID, d2r_eve_ptr = register[ptr[3:0]].
  - If ptr[3:0] >= NUM_REGS, d2r_eve_ptr = 40'hFF_FFFF_FFFF.
  - Outputs are held stable until d2r_eve_ack is sampled high; d2r_eve_stb goes low on the following edge.
  - A READ is refused while a response is pending.
- Any other command is acked immediately and dropped, with no state change.
- Reset mid-operation: a pending response is abandoned (d2r_eve_stb = 0) and the FIFO contents are lost.

Decomposition:
- Package rbus_eve_pkg holds:
  - the 40-bit pointer width constant;
  - command-offset constants for PUSH, READ and RSP;
  - the error-payload constant;
  - a clog2 function.
- One sub-module: rbus_sync_fifo (parametrised width and depth, show-ahead, level output). It is reused for any future device stream.

Test Plan:
- Reset with defaults, INI_VALS[79:40] = 40'h500 -> cfg_regs reg1 = 40'h500; all outputs at their reset values; str_stb = 0.
- Event cmd 8'h22, ptr 40'h1234 -> ack the same cycle; reg2 = 40'h1234 the next cycle; cfg_upd = 8'b0000_0100 for exactly 1 cycle.
- Five PUSH events (cmd 8'h28, data 'A'..'E') with str_ack = 0 -> first 4 acked; 5th stalls with ack = 0 and str_level = 4; one str_ack pops 'A'; 5th acked the next cycle; final order A,B,C,D,E.
- READ (cmd 8'h29, ptr 2) with d2r_eve_ack held low 3 cycles -> d2r_eve_stb = 1, cmd 8'h2A, ptr 40'h1234, stable for 3 cycles; a second READ is refused until the ack; after the ack, stb = 0.
- READ with ptr 9 -> response ptr 40'hFF_FFFF_FFFF. Unknown cmd 8'h10 -> acked, no change to registers, FIFO or response.
- soft_rst asserted while a response is pending and the FIFO holds 2 entries -> the next cycle d2r_eve_stb = 0, str_level = 0, registers back to INI_VALS.

Source files
------------

// File: rtl/rbus_eve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbus_eve_pkg
// Description : Shared constants and helpers for ring-bus event config banks.
// Revision    : 1.0 - initial release
// ============================================================================
package rbus_eve_pkg;

    // Width of an event payload pointer
    localparam int c_PTR_W = 40;

    // Command offsets relative to CMD_BASE + NUM_REGS
    localparam logic [7:0] c_PUSH_OFS = 8'd0;
    localparam logic [7:0] c_READ_OFS = 8'd1;
    localparam logic [7:0] c_RSP_OFS  = 8'd2;

    // Payload returned when a read targets a non-existent register
    localparam logic [c_PTR_W-1:0] c_ERR_PTR = 40'hFF_FFFF_FFFF;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rbus_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rbus_sync_fifo
// Description : Show-ahead synchronous FIFO with occupancy output. DEPTH must
//               be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module rbus_sync_fifo
    import rbus_eve_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   level
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_LW'(DEPTH));
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign level     = r_level;

    // Storage array; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rbus_eve_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module      : rbus_eve_cfg_bank
// Description : Ring-bus event driven configuration bank: register writes,
//               byte-stream FIFO and register readback via response events.
// Revision    : 1.0 - initial release
// ============================================================================
module rbus_eve_cfg_bank
    import rbus_eve_pkg::*;
#(
    parameter int                            NUM_REGS   = 8,
    parameter logic [7:0]                    CMD_BASE   = 8'h20,
    parameter logic [NUM_REGS*c_PTR_W-1:0]   INI_VALS   = '0,
    parameter int                            FIFO_DEPTH = 4,
    parameter int                            FIFO_W     = 8,
    parameter logic [7:0]                    DEV_ID     = 8'h00
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             soft_rst,
    input  logic                             r2d_eve_stb,
    input  logic [7:0]                       r2d_eve_cmd,
    input  logic [c_PTR_W-1:0]               r2d_eve_ptr,
    output logic                             r2d_eve_ack,
    output logic                             d2r_eve_stb,
    output logic [7:0]                       d2r_eve_cmd,
    output logic [7:0]                       d2r_eve_dev,
    output logic [c_PTR_W-1:0]               d2r_eve_ptr,
    input  logic                             d2r_eve_ack,
    output logic [NUM_REGS*c_PTR_W-1:0]      cfg_regs,
    output logic [NUM_REGS-1:0]              cfg_upd,
    output logic                             str_stb,
    output logic [FIFO_W-1:0]                str_data,
    input  logic                             str_ack,
    output logic [clog2(FIFO_DEPTH):0]       str_level
);

    localparam logic [7:0] c_NREG     = 8'(NUM_REGS);
    localparam logic [7:0] c_PUSH_CMD = CMD_BASE + c_NREG + c_PUSH_OFS;
    localparam logic [7:0] c_READ_CMD = CMD_BASE + c_NREG + c_READ_OFS;
    localparam logic [7:0] c_RSP_CMD  = CMD_BASE + c_NREG + c_RSP_OFS;

    logic                  w_rst;
    logic [7:0]            w_ofs;
    logic                  w_is_reg;
    logic                  w_is_push;
    logic                  w_is_read;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push_ok;
    logic                  w_read_ok;
    logic [NUM_REGS-1:0]   w_upd_nxt;
    logic [c_PTR_W-1:0]    w_rd_data;

    logic [c_PTR_W-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_upd;
    logic                  r_rsp_stb;
    logic [7:0]            r_rsp_cmd;
    logic [7:0]            r_rsp_dev;
    logic [c_PTR_W-1:0]    r_rsp_ptr;

    assign w_rst     = rst | soft_rst;
    assign w_ofs     = r2d_eve_cmd - CMD_BASE;
    // The lower-bound check stops 8-bit wrap of w_ofs aliasing low commands
    assign w_is_reg  = (r2d_eve_cmd >= CMD_BASE) && (w_ofs < c_NREG);
    assign w_is_push = (r2d_eve_cmd == c_PUSH_CMD);
    assign w_is_read = (r2d_eve_cmd == c_READ_CMD);

    // Push acceptance looks only at the registered level, never at str_ack
    assign w_push_ok = r2d_eve_stb && w_is_push && !w_fifo_full;
    assign w_read_ok = r2d_eve_stb && w_is_read && !r_rsp_stb;

    assign r2d_eve_ack = r2d_eve_stb &&
                         (w_is_reg ||
                          (w_is_push && !w_fifo_full) ||
                          (w_is_read && !r_rsp_stb) ||
                          !(w_is_reg || w_is_push || w_is_read));

    // One-hot write enable for the addressed register
    always_comb begin
        w_upd_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r2d_eve_stb && w_is_reg && (w_ofs == 8'(i))) begin
                w_upd_nxt[i] = 1'b1;
            end
        end
    end

    // Register file and its update pulses
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_upd <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= INI_VALS[i*c_PTR_W +: c_PTR_W];
            end
        end else begin
            r_upd <= w_upd_nxt;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_upd_nxt[i]) begin
                    r_regs[i] <= r2d_eve_ptr;
                end
            end
        end
    end

    // Readback mux; unimplemented indices return the error payload
    always_comb begin
        w_rd_data = c_ERR_PTR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r2d_eve_ptr[3:0] == 4'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Response event: held until the ring acks it, then dropped next edge
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_rsp_stb <= 1'b0;
            r_rsp_cmd <= '0;
            r_rsp_dev <= '0;
            r_rsp_ptr <= '0;
        end else if (r_rsp_stb) begin
            if (d2r_eve_ack) begin
                r_rsp_stb <= 1'b0;
            end
        end else if (w_read_ok) begin
            r_rsp_stb <= 1'b1;
            r_rsp_cmd <= c_RSP_CMD;
            r_rsp_dev <= DEV_ID;
            r_rsp_ptr <= w_rd_data;
        end
    end

    assign d2r_eve_stb = r_rsp_stb;
    assign d2r_eve_cmd = r_rsp_cmd;
    assign d2r_eve_dev = r_rsp_dev;
    assign d2r_eve_ptr = r_rsp_ptr;
    assign cfg_upd     = r_upd;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
            assign cfg_regs[g*c_PTR_W +: c_PTR_W] = r_regs[g];
        end
    endgenerate

    rbus_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_str_fifo (
        .clk       (clk),
        .rst       (w_rst),
        .push      (w_push_ok),
        .push_data (r2d_eve_ptr[FIFO_W-1:0]),
        .pop       (str_ack),
        .head      (str_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (str_level)
    );

    assign str_stb = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_rbus_eve_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbus_eve_cfg_bank
// Description : Self-checking bench: directed scenarios followed by random
//               event traffic compared against a queue/array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbus_eve_cfg_bank;

    localparam int          c_NR    = 8;
    localparam logic [7:0]  c_DEV   = 8'hA7;
    localparam logic [c_NR*40-1:0] c_INI = (c_NR*40)'(40'h500) << 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               soft_rst = 1'b0;
    logic               r2d_eve_stb = 1'b0;
    logic [7:0]         r2d_eve_cmd = '0;
    logic [39:0]        r2d_eve_ptr = '0;
    logic               r2d_eve_ack;
    logic               d2r_eve_stb;
    logic [7:0]         d2r_eve_cmd;
    logic [7:0]         d2r_eve_dev;
    logic [39:0]        d2r_eve_ptr;
    logic               d2r_eve_ack = 1'b0;
    logic [c_NR*40-1:0] cfg_regs;
    logic [c_NR-1:0]    cfg_upd;
    logic               str_stb;
    logic [7:0]         str_data;
    logic               str_ack = 1'b0;
    logic [2:0]         str_level;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [39:0] m_regs [c_NR];
    logic [7:0]  m_q [$];
    bit          m_pend;
    logic [39:0] m_rsp;

    rbus_eve_cfg_bank #(
        .NUM_REGS   (c_NR),
        .CMD_BASE   (8'h20),
        .INI_VALS   (c_INI),
        .FIFO_DEPTH (4),
        .FIFO_W     (8),
        .DEV_ID     (c_DEV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst    (soft_rst),
        .r2d_eve_stb (r2d_eve_stb),
        .r2d_eve_cmd (r2d_eve_cmd),
        .r2d_eve_ptr (r2d_eve_ptr),
        .r2d_eve_ack (r2d_eve_ack),
        .d2r_eve_stb (d2r_eve_stb),
        .d2r_eve_cmd (d2r_eve_cmd),
        .d2r_eve_dev (d2r_eve_dev),
        .d2r_eve_ptr (d2r_eve_ptr),
        .d2r_eve_ack (d2r_eve_ack),
        .cfg_regs    (cfg_regs),
        .cfg_upd     (cfg_upd),
        .str_stb     (str_stb),
        .str_data    (str_data),
        .str_ack     (str_ack),
        .str_level   (str_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] reg_of(input int i);
        return cfg_regs[i*40 +: 40];
    endfunction

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an event and let the combinational ack settle
    task automatic drive(input logic stb, input logic [7:0] cmd, input logic [39:0] ptr);
        r2d_eve_stb = stb;
        r2d_eve_cmd = cmd;
        r2d_eve_ptr = ptr;
        #1;
    endtask

    task automatic check_ini(input string tag);
        for (int i = 0; i < c_NR; i++) begin
            check(tag, 64'(reg_of(i)), (i == 1) ? 64'h500 : 64'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cmd;
        logic [39:0] ptr;
        logic        stb, exp_ack;
        int          sel, idx;

        // ---------------- reset ----------------
        tick(); tick();
        rst = 1'b0;
        #1;
        check_ini("reset_regs");
        check("reset_upd", 64'(cfg_upd), 64'h0);
        check("reset_d2r_stb", 64'(d2r_eve_stb), 64'h0);
        check("reset_d2r_cmd", 64'(d2r_eve_cmd), 64'h0);
        check("reset_d2r_dev", 64'(d2r_eve_dev), 64'h0);
        check("reset_d2r_ptr", 64'(d2r_eve_ptr), 64'h0);
        check("reset_str_stb", 64'(str_stb), 64'h0);
        check("reset_level", 64'(str_level), 64'h0);
        check("reset_ack", 64'(r2d_eve_ack), 64'h0);

        // ---------------- register write ----------------
        drive(1'b1, 8'h22, 40'h1234);
        check("wr_ack", 64'(r2d_eve_ack), 64'h1);
        tick();
        drive(1'b0, 8'h00, 40'h0);
        check("wr_reg2", 64'(reg_of(2)), 64'h1234);
        check("wr_upd", 64'(cfg_upd), 64'h04);
        tick();
        check("wr_upd_clear", 64'(cfg_upd), 64'h0);

        // ---------------- FIFO fill / stall / drain ----------------
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'h28, 40'(8'h41 + k));
            check("push_ack", 64'(r2d_eve_ack), 64'h1);
            tick();
        end
        drive(1'b1, 8'h28, 40'h45);
        check("push_full_ack", 64'(r2d_eve_ack), 64'h0);
        check("push_full_level", 64'(str_level), 64'h4);
        check("push_head_A", 64'(str_data), 64'h41);
        str_ack = 1'b1;
        #1;
        check("push_full_pop_ack", 64'(r2d_eve_ack), 64'h0);
        tick();
        str_ack = 1'b0;
        #1;
        check("pop_head_B", 64'(str_data), 64'h42);
        check("pop_level", 64'(str_level), 64'h3);
        check("push5_ack", 64'(r2d_eve_ack), 64'h1);
        tick();
        drive(1'b0, 8'h00, 40'h0);
        check("push5_level", 64'(str_level), 64'h4);
        for (int k = 1; k < 5; k++) begin
            check("drain_stb", 64'(str_stb), 64'h1);
            check("drain_data", 64'(str_data), 64'(8'h41 + k));
            str_ack = 1'b1;
            tick();
        end
        str_ack = 1'b0;
        #1;
        check("drain_empty", 64'(str_stb), 64'h0);
        check("drain_level", 64'(str_level), 64'h0);
        str_ack = 1'b1;
        tick();
        str_ack = 1'b0;
        check("empty_pop_level", 64'(str_level), 64'h0);

        // ---------------- READ with delayed ack ----------------
        drive(1'b1, 8'h29, 40'h2);
        check("rd_ack", 64'(r2d_eve_ack), 64'h1);
        tick();
        drive(1'b1, 8'h29, 40'h1);
        for (int j = 0; j < 3; j++) begin
            check("rsp_stb", 64'(d2r_eve_stb), 64'h1);
            check("rsp_cmd", 64'(d2r_eve_cmd), 64'h2A);
            check("rsp_dev", 64'(d2r_eve_dev), 64'(c_DEV));
            check("rsp_ptr", 64'(d2r_eve_ptr), 64'h1234);
            check("rd2_refused", 64'(r2d_eve_ack), 64'h0);
            tick();
        end
        d2r_eve_ack = 1'b1;
        #1;
        check("rd2_refused_at_ack", 64'(r2d_eve_ack), 64'h0);
        tick();
        d2r_eve_ack = 1'b0;
        #1;
        check("rsp_stb_drop", 64'(d2r_eve_stb), 64'h0);
        check("rd2_ack", 64'(r2d_eve_ack), 64'h1);
        tick();
        drive(1'b0, 8'h00, 40'h0);
        check("rd2_stb", 64'(d2r_eve_stb), 64'h1);
        check("rd2_ptr", 64'(d2r_eve_ptr), 64'h500);
        d2r_eve_ack = 1'b1;
        tick();
        d2r_eve_ack = 1'b0;

        // ---------------- READ out of range ----------------
        drive(1'b1, 8'h29, 40'h9);
        check("rd9_ack", 64'(r2d_eve_ack), 64'h1);
        tick();
        drive(1'b0, 8'h00, 40'h0);
        check("rd9_ptr", 64'(d2r_eve_ptr), 64'hFF_FFFF_FFFF);
        d2r_eve_ack = 1'b1;
        tick();
        d2r_eve_ack = 1'b0;

        // ---------------- unknown command ----------------
        drive(1'b1, 8'h10, 40'hDE_ADBE_EF00);
        check("unk_ack", 64'(r2d_eve_ack), 64'h1);
        tick();
        drive(1'b0, 8'h00, 40'h0);
        check("unk_reg1", 64'(reg_of(1)), 64'h500);
        check("unk_reg2", 64'(reg_of(2)), 64'h1234);
        check("unk_upd", 64'(cfg_upd), 64'h0);
        check("unk_level", 64'(str_level), 64'h0);
        check("unk_rsp", 64'(d2r_eve_stb), 64'h0);

        // ---------------- soft reset mid-operation ----------------
        drive(1'b1, 8'h28, 40'h61); tick();
        drive(1'b1, 8'h28, 40'h62); tick();
        drive(1'b1, 8'h29, 40'h2);  tick();
        drive(1'b0, 8'h00, 40'h0);
        check("pre_srst_level", 64'(str_level), 64'h2);
        check("pre_srst_rsp", 64'(d2r_eve_stb), 64'h1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        check("srst_rsp", 64'(d2r_eve_stb), 64'h0);
        check("srst_level", 64'(str_level), 64'h0);
        check("srst_str_stb", 64'(str_stb), 64'h0);
        check_ini("srst_regs");

        // ---------------- random traffic vs reference model ----------------
        for (int i = 0; i < c_NR; i++) m_regs[i] = (i == 1) ? 40'h500 : 40'h0;
        m_q.delete();
        m_pend = 1'b0;
        m_rsp  = '0;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            stb = 1'b1;
            ptr = {$urandom(), 8'($urandom())};
            if (sel <= 2) begin
                cmd = 8'h20 + 8'($urandom_range(0, c_NR - 1));
            end else if (sel <= 5) begin
                cmd = 8'h28;
            end else if (sel <= 7) begin
                cmd = 8'h29;
            end else if (sel == 8) begin
                cmd = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                  : 8'($urandom_range(43, 255));
            end else begin
                stb = 1'b0;
                cmd = 8'h20;
            end
            str_ack     = 1'($urandom_range(0, 1));
            d2r_eve_ack = ($urandom_range(0, 2) == 0);
            drive(stb, cmd, ptr);

            // expected acceptance from the model's current state
            if (!stb)                          exp_ack = 1'b0;
            else if (cmd >= 8'h20 && cmd < 8'h28) exp_ack = 1'b1;
            else if (cmd == 8'h28)             exp_ack = (m_q.size() < 4);
            else if (cmd == 8'h29)             exp_ack = !m_pend;
            else                               exp_ack = 1'b1;
            check("rnd_ack", 64'(r2d_eve_ack), 64'(exp_ack));

            // model update for the coming edge
            if (m_pend && d2r_eve_ack) begin
                m_pend = 1'b0;
            end else if (!m_pend && exp_ack && cmd == 8'h29) begin
                m_pend = 1'b1;
                idx    = int'(ptr[3:0]);
                m_rsp  = (idx < c_NR) ? m_regs[idx] : 40'hFF_FFFF_FFFF;
            end
            if (str_ack && m_q.size() > 0) void'(m_q.pop_front());
            if (exp_ack && cmd == 8'h28) m_q.push_back(ptr[7:0]);
            if (exp_ack && cmd >= 8'h20 && cmd < 8'h28) m_regs[cmd - 8'h20] = ptr;

            tick();
            idx = (stb && cmd >= 8'h20 && cmd < 8'h28) ? int'(cmd - 8'h20) : -1;
            check("rnd_upd", 64'(cfg_upd), (idx >= 0) ? (64'h1 << idx) : 64'h0);
            for (int i = 0; i < c_NR; i++) begin
                check("rnd_reg", 64'(reg_of(i)), 64'(m_regs[i]));
            end
            check("rnd_level", 64'(str_level), 64'(m_q.size()));
            check("rnd_str_stb", 64'(str_stb), 64'(m_q.size() > 0));
            if (m_q.size() > 0) check("rnd_str_data", 64'(str_data), 64'(m_q[0]));
            check("rnd_rsp_stb", 64'(d2r_eve_stb), 64'(m_pend));
            if (m_pend) begin
                check("rnd_rsp_ptr", 64'(d2r_eve_ptr), 64'(m_rsp));
                check("rnd_rsp_cmd", 64'(d2r_eve_cmd), 64'h2A);
                check("rnd_rsp_dev", 64'(d2r_eve_dev), 64'(c_DEV));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
